// File: rtl/fdiv_ratio_meter.sv
// fdiv_ratio_meter: measures the average division ratio of a registered divider
// output by counting clk cycles per fdiv period over 2^LOG2_WIN periods.
// Result is fixed point: PER_WIDTH integer bits, LOG2_WIN fraction bits.
module fdiv_ratio_meter #(
   parameter int unsigned INT_WIDTH = 8,
   parameter int unsigned PER_WIDTH = INT_WIDTH + 1,
   parameter int unsigned LOG2_WIN  = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          fdiv,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic [PER_WIDTH+LOG2_WIN-1:0] ratio,
   output logic [PER_WIDTH-1:0]          per_min,
   output logic [PER_WIDTH-1:0]          per_max,
   output logic                          ovf
);

   localparam int unsigned ACC_W  = PER_WIDTH + LOG2_WIN;
   localparam int unsigned EDGE_W = LOG2_WIN + 1;
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'((1 << LOG2_WIN) - 1);

   typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

   state_t               state;
   logic                 fdiv_d;
   logic                 rise;
   logic [PER_WIDTH-1:0] per_cnt;
   logic [ACC_W-1:0]     acc;
   logic [PER_WIDTH-1:0] min_r;
   logic [PER_WIDTH-1:0] max_r;
   logic [EDGE_W-1:0]    edges;

   logic [ACC_W-1:0]     acc_nxt;
   logic [PER_WIDTH-1:0] min_nxt;
   logic [PER_WIDTH-1:0] max_nxt;
   logic                 per_sat;

   assign rise = fdiv & ~fdiv_d;

   // Running sum and extremes including the period that closes at this rise.
   always_comb begin
      acc_nxt = acc + ACC_W'(per_cnt);
      min_nxt = (per_cnt < min_r) ? per_cnt : min_r;
      max_nxt = (per_cnt > max_r) ? per_cnt : max_r;
      per_sat = &per_cnt;
   end

   // Delay fdiv by one cycle for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) fdiv_d <= 1'b0;
      else     fdiv_d <= fdiv;
   end

   // Window FSM; results are registered on the edge that ends the window so
   // that done and the results appear together in the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         ratio   <= '0;
         per_min <= '0;
         per_max <= '0;
         ovf     <= 1'b0;
         per_cnt <= '0;
         acc     <= '0;
         min_r   <= '1;
         max_r   <= '0;
         edges   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               acc     <= '0;
               min_r   <= '1;
               max_r   <= '0;
               edges   <= '0;
               per_cnt <= '0;
               if (start) begin
                  state <= ARM;
                  busy  <= 1'b1;
               end
            end
            ARM: begin
               // per_cnt doubles as the timeout counter while waiting for the first rise
               if (rise) begin
                  per_cnt <= PER_WIDTH'(1);
                  state   <= MEAS;
               end else if (per_sat) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  ratio   <= '1;
                  per_min <= min_r;
                  per_max <= max_r;
                  ovf     <= 1'b1;
               end else begin
                  per_cnt <= per_cnt + PER_WIDTH'(1);
               end
            end
            MEAS: begin
               if (rise) begin
                  acc     <= acc_nxt;
                  min_r   <= min_nxt;
                  max_r   <= max_nxt;
                  per_cnt <= PER_WIDTH'(1);
                  edges   <= edges + EDGE_W'(1);
                  if (edges == LAST_EDGE) begin
                     state   <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     ratio   <= acc_nxt;
                     per_min <= min_nxt;
                     per_max <= max_nxt;
                     ovf     <= 1'b0;
                  end
               end else if (per_sat) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  ratio   <= '1;
                  per_min <= min_r;
                  per_max <= max_r;
                  ovf     <= 1'b1;
               end else begin
                  per_cnt <= per_cnt + PER_WIDTH'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fdiv_ratio_meter.sv
// tb_fdiv_ratio_meter: randomized windows of fdiv periods; expected results are
// computed from the period list and queued, a monitor pops them on done.
module tb_fdiv_ratio_meter;

   localparam int unsigned INT_WIDTH = 8;
   localparam int unsigned PER_WIDTH = INT_WIDTH + 1;
   localparam int unsigned LOG2_WIN  = 4;
   localparam int unsigned RW        = PER_WIDTH + LOG2_WIN;
   localparam int          WIN       = 1 << LOG2_WIN;

   typedef struct {
      logic [RW-1:0]        ratio;
      logic [PER_WIDTH-1:0] mn;
      logic [PER_WIDTH-1:0] mx;
      logic                 ovf;
      int                   busy_cyc;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 fdiv;
   logic                 start;
   logic                 busy;
   logic                 done;
   logic [RW-1:0]        ratio;
   logic [PER_WIDTH-1:0] per_min;
   logic [PER_WIDTH-1:0] per_max;
   logic                 ovf;

   exp_t sbq[$];
   exp_t mon_e;
   int   per_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   n_done = 0;
   int   n_win  = 0;
   int   bcnt   = 0;

   fdiv_ratio_meter #(.INT_WIDTH(INT_WIDTH), .PER_WIDTH(PER_WIDTH), .LOG2_WIN(LOG2_WIN)) dut (
      .clk(clk), .rst(rst), .fdiv(fdiv), .start(start), .busy(busy), .done(done),
      .ratio(ratio), .per_min(per_min), .per_max(per_max), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Monitor: counts busy cycles per window and checks results on every done.
   always @(negedge clk) begin
      if (rst) begin
         bcnt = 0;
      end else begin
         if (busy) bcnt++;
         if (done) begin
            n_done++;
            if (sbq.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_done: got done=1 required no done");
            end else begin
               mon_e = sbq.pop_front();
               chk("ratio",   32'(ratio),   32'(mon_e.ratio));
               chk("per_min", 32'(per_min), 32'(mon_e.mn));
               chk("per_max", 32'(per_max), 32'(mon_e.mx));
               chk("ovf",     32'(ovf),     32'(mon_e.ovf));
               if (mon_e.busy_cyc >= 0) chk("busy_cycles", 32'(bcnt), 32'(mon_e.busy_cyc));
            end
            bcnt = 0;
         end
      end
   end

   task automatic cyc(input logic f, input logic s);
      @(negedge clk);
      fdiv  = f;
      start = s;
   endtask

   // nrise = WIN+1 gives a full window; fewer rises leave fdiv stuck low afterwards.
   task automatic run_window(input int lead, input bit poke, input int nrise);
      exp_t e;
      int   s, mn, mx, np, hi;
      np = (nrise > 0) ? nrise - 1 : 0;
      s  = 0;
      mn = (1 << PER_WIDTH) - 1;
      mx = 0;
      for (int i = 0; i < np; i++) begin
         s += per_q[i];
         if (per_q[i] < mn) mn = per_q[i];
         if (per_q[i] > mx) mx = per_q[i];
      end
      if (nrise == WIN + 1)
         e = '{ratio: RW'(s), mn: PER_WIDTH'(mn), mx: PER_WIDTH'(mx), ovf: 1'b0, busy_cyc: 1 + lead + s};
      else
         e = '{ratio: {RW{1'b1}}, mn: PER_WIDTH'(mn), mx: PER_WIDTH'(mx), ovf: 1'b1, busy_cyc: -1};
      sbq.push_back(e);
      n_win++;
      cyc(1'b0, 1'b1);
      repeat (lead) cyc(1'b0, poke && ($urandom_range(0, 1) == 1));
      for (int r = 0; r < nrise; r++) begin
         if (r == nrise - 1) begin
            cyc(1'b1, poke && ($urandom_range(0, 1) == 1));
         end else begin
            hi = per_q[r] / 2;
            for (int c = 0; c < per_q[r]; c++) cyc(c < hi, poke && ($urandom_range(0, 1) == 1));
         end
      end
      if (nrise == WIN + 1) begin
         cyc(1'b0, poke);
         cyc(1'b0, 1'b0);
      end else begin
         repeat (540) cyc(1'b0, 1'b0);
      end
      for (int c = 0; c < 600 && sbq.size() > 0; c++) cyc(1'b0, 1'b0);
      if (sbq.size() > 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL done_timeout: got %0d pending results required 0", sbq.size());
         sbq.delete();
      end
      repeat (3) cyc(1'b0, 1'b0);
   endtask

   task automatic fill_rand(input int lo, input int hi);
      per_q.delete();
      for (int i = 0; i < WIN; i++) per_q.push_back($urandom_range(lo, hi));
   endtask

   initial begin
      rst   = 1'b1;
      fdiv  = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",    32'(busy),    0);
      chk("rst_done",    32'(done),    0);
      chk("rst_ratio",   32'(ratio),   0);
      chk("rst_per_min", 32'(per_min), 0);
      chk("rst_per_max", 32'(per_max), 0);
      chk("rst_ovf",     32'(ovf),     0);
      rst = 1'b0;
      repeat (2) cyc(1'b0, 1'b0);

      // constant period 10
      per_q.delete();
      for (int i = 0; i < WIN; i++) per_q.push_back(10);
      run_window(2, 1'b0, WIN + 1);

      // alternating 10/11
      per_q.delete();
      for (int i = 0; i < WIN; i++) per_q.push_back((i % 2 == 0) ? 10 : 11);
      run_window(0, 1'b0, WIN + 1);

      // minimum period
      per_q.delete();
      for (int i = 0; i < WIN; i++) per_q.push_back(2);
      run_window(1, 1'b0, WIN + 1);

      // random periods with start pulses during ARM, MEAS and DONE
      for (int k = 0; k < 6; k++) begin
         fill_rand(2, 24);
         run_window($urandom_range(0, 3), 1'b1, WIN + 1);
      end
      chk("busy_after_ignored_start", 32'(busy), 0);

      // long periods
      fill_rand(100, 400);
      run_window(0, 1'b0, WIN + 1);

      // stuck low in ARM: timeout abort
      run_window(0, 1'b0, 0);

      // stuck low after four periods: saturation abort
      fill_rand(5, 30);
      run_window(1, 1'b0, 5);

      // reset in the middle of a window
      fill_rand(4, 12);
      cyc(1'b0, 1'b1);
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < per_q[r]; c++) cyc(c < per_q[r] / 2, 1'b0);
      @(negedge clk);
      rst  = 1'b1;
      fdiv = 1'b0;
      @(negedge clk);
      chk("midrst_busy",    32'(busy),    0);
      chk("midrst_done",    32'(done),    0);
      chk("midrst_ratio",   32'(ratio),   0);
      chk("midrst_per_min", 32'(per_min), 0);
      chk("midrst_per_max", 32'(per_max), 0);
      chk("midrst_ovf",     32'(ovf),     0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) cyc(1'b0, 1'b0);

      // fresh window after reset
      fill_rand(2, 20);
      run_window(2, 1'b0, WIN + 1);

      repeat (20) cyc(1'b0, 1'b0);
      chk("done_count", 32'(n_done), 32'(n_win));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
